// File: rtl/mult_seq_unsigned_dmr.sv
// Sequential radix-2 shift-add unsigned multiplier with optional shadow datapath
// (dual modular redundancy) for fault detection.
// Ports:
//   clk, rst_n             : clock, asynchronous active-low reset
//   in_valid/in_ready, a, b: operand handshake (sampled only at acceptance)
//   out_valid/out_ready    : product handshake; product held under back-pressure
//   product                : a*b, 2*WIDTH bits
//   fault                  : primary/shadow mismatch seen during this operation
//   fault_sticky/fault_clr : latched fault history and its synchronous clear
//   busy                   : operation in progress (RUN or DONE)
module mult_seq_unsigned_dmr #(
    parameter int unsigned WIDTH    = 4,
    parameter bit          CHECK_EN = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 fault,
    output logic                 fault_sticky,
    input  logic                 fault_clr,
    output logic                 busy
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [PW-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplr_q, mplr_d;
    logic [PW-1:0] acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          in_ready_q, in_ready_d;
    logic          out_valid_q, out_valid_d;
    logic          busy_q, busy_d;
    logic [PW-1:0] product_q, product_d;
    logic          op_fault_q, op_fault_d;
    logic          fault_q, fault_d;
    logic          sticky_q, sticky_d;

    logic          accept_c;
    logic          illegal_c;
    logic          mismatch_c;

    (* keep = "true" *) logic [PW-1:0]    s_mcand_q;
    (* keep = "true" *) logic [WIDTH-1:0] s_mplr_q;
    (* keep = "true" *) logic [PW-1:0]    s_acc_q;
    (* keep = "true" *) logic [CW-1:0]    s_cnt_q;
    logic [PW-1:0]    s_mcand_d;
    logic [WIDTH-1:0] s_mplr_d;
    logic [PW-1:0]    s_acc_d;
    logic [CW-1:0]    s_cnt_d;

    // Primary FSM and datapath next-state
    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplr_d    = mplr_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        accept_c  = 1'b0;
        illegal_c = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    accept_c = 1'b1;
                    mcand_d  = PW'(a);
                    mplr_d   = b;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                if (mplr_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d = mcand_q << 1;
                mplr_d  = mplr_q >> 1;
                cnt_d   = cnt_q + CW'(1);
                // Fixed WIDTH iterations keeps latency data-independent
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d   = S_IDLE;
                illegal_c = 1'b1;
            end
        endcase
    end

    // Shadow datapath shares control but keeps its own state
    generate
        if (CHECK_EN) begin : g_shadow
            always_comb begin
                s_mcand_d = s_mcand_q;
                s_mplr_d  = s_mplr_q;
                s_acc_d   = s_acc_q;
                s_cnt_d   = s_cnt_q;
                if (accept_c) begin
                    s_mcand_d = PW'(a);
                    s_mplr_d  = b;
                    s_acc_d   = '0;
                    s_cnt_d   = '0;
                end else if (state_q == S_RUN) begin
                    if (s_mplr_q[0]) begin
                        s_acc_d = s_acc_q + s_mcand_q;
                    end
                    s_mcand_d = s_mcand_q << 1;
                    s_mplr_d  = s_mplr_q >> 1;
                    s_cnt_d   = s_cnt_q + CW'(1);
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s_mcand_q <= '0;
                    s_mplr_q  <= '0;
                    s_acc_q   <= '0;
                    s_cnt_q   <= '0;
                end else begin
                    s_mcand_q <= s_mcand_d;
                    s_mplr_q  <= s_mplr_d;
                    s_acc_q   <= s_acc_d;
                    s_cnt_q   <= s_cnt_d;
                end
            end
        end else begin : g_no_shadow
            assign s_mcand_q = '0;
            assign s_mplr_q  = '0;
            assign s_acc_q   = '0;
            assign s_cnt_q   = '0;
            assign s_mcand_d = '0;
            assign s_mplr_d  = '0;
            assign s_acc_d   = '0;
            assign s_cnt_d   = '0;
        end
    endgenerate

    // Compare current and next state in RUN; the next-state compare on the
    // final iteration covers the DONE entry before out_valid rises.
    always_comb begin
        mismatch_c = 1'b0;
        if (CHECK_EN && (state_q == S_RUN)) begin
            mismatch_c = (mcand_q != s_mcand_q) || (mplr_q != s_mplr_q) ||
                         (acc_q   != s_acc_q)   || (cnt_q  != s_cnt_q)  ||
                         (mcand_d != s_mcand_d) || (mplr_d != s_mplr_d) ||
                         (acc_d   != s_acc_d)   || (cnt_d  != s_cnt_d);
        end
    end

    // Registered outputs and fault bookkeeping
    always_comb begin
        in_ready_d  = (state_d == S_IDLE);
        out_valid_d = (state_d == S_DONE);
        busy_d      = (state_d == S_RUN) || (state_d == S_DONE);
        product_d   = product_q;
        if ((state_q == S_RUN) && (state_d == S_DONE)) begin
            product_d = acc_d;
        end
        op_fault_d = accept_c ? 1'b0 : (op_fault_q | mismatch_c);
        fault_d    = (state_d == S_DONE) ? op_fault_d : 1'b0;
        // Set has priority over clear
        sticky_d   = mismatch_c | illegal_c | (sticky_q & ~fault_clr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            mcand_q     <= '0;
            mplr_q      <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            product_q   <= '0;
            op_fault_q  <= 1'b0;
            fault_q     <= 1'b0;
            sticky_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            mcand_q     <= mcand_d;
            mplr_q      <= mplr_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            product_q   <= product_d;
            op_fault_q  <= op_fault_d;
            fault_q     <= fault_d;
            sticky_q    <= sticky_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign out_valid    = out_valid_q;
    assign busy         = busy_q;
    assign product      = product_q;
    assign fault        = fault_q;
    assign fault_sticky = sticky_q;

endmodule
